// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-rate constants and the receive state encoding.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 434;
   localparam int SIM_CLKS_PER_BIT     = 6;
   localparam int UART_DATA_BITS       = 8;

   typedef enum logic [2:0] {
      S_RX_IDLE,
      S_RX_START_BIT,
      S_RX_DATA_BITS,
      S_RX_STOP_BIT,
      S_RX_WAIT_IDLE
   } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic Resetn,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   always_ff @(posedge clk or negedge Resetn) begin
      if (!Resetn) begin
         meta     <= RESET_VALUE;
         sync_out <= RESET_VALUE;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_controller.sv
// UART 8N1 receiver: deserialises a frame into a one-byte holding register
// with Full/Read handshake and sticky Overrun and Frame_error flags.
module uart_rx_controller
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic                      clk,
   input  logic                      Resetn,
   input  logic                      UART_RX_I,
   input  logic                      Read,
   output logic [UART_DATA_BITS-1:0] r_data,
   output logic                      Full,
   output logic                      Overrun,
   output logic                      Frame_error
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

   rx_state_t                 state;
   logic [CW-1:0]             clock_count;
   logic [2:0]                data_count;
   logic [UART_DATA_BITS-1:0] shift;
   logic                      rx_s;
   logic                      stop_sample;

   uart_sync2 #(
      .RESET_VALUE(1'b1)
   ) u_sync (
      .clk     (clk),
      .Resetn  (Resetn),
      .async_in(UART_RX_I),
      .sync_out(rx_s)
   );

   assign stop_sample = (state == S_RX_STOP_BIT) && (clock_count == BIT_LAST);

   always_ff @(posedge clk or negedge Resetn) begin
      if (!Resetn) begin
         state       <= S_RX_IDLE;
         clock_count <= '0;
         data_count  <= '0;
         shift       <= '0;
         r_data      <= '0;
         Full        <= 1'b0;
         Overrun     <= 1'b0;
         Frame_error <= 1'b0;
      end else begin
         case (state)
            S_RX_IDLE: begin
               clock_count <= '0;
               data_count  <= '0;
               if (!rx_s) state <= S_RX_START_BIT;
            end
            S_RX_START_BIT: begin
               if (clock_count == HALF_LAST) begin
                  clock_count <= '0;
                  state       <= rx_s ? S_RX_IDLE : S_RX_DATA_BITS;
               end else begin
                  clock_count <= clock_count + 1'b1;
               end
            end
            S_RX_DATA_BITS: begin
               if (clock_count == BIT_LAST) begin
                  clock_count <= '0;
                  shift       <= {rx_s, shift[UART_DATA_BITS-1:1]};
                  data_count  <= data_count + 1'b1;
                  if (data_count == LAST_BIT) state <= S_RX_STOP_BIT;
               end else begin
                  clock_count <= clock_count + 1'b1;
               end
            end
            S_RX_STOP_BIT: begin
               if (clock_count == BIT_LAST) begin
                  clock_count <= '0;
                  state       <= rx_s ? S_RX_IDLE : S_RX_WAIT_IDLE;
               end else begin
                  clock_count <= clock_count + 1'b1;
               end
            end
            // A held-low line (break) must return high before a new start can be seen
            S_RX_WAIT_IDLE: begin
               if (rx_s) state <= S_RX_IDLE;
            end
            default: state <= S_RX_IDLE;
         endcase

         // A same-cycle Read frees the holding register, so the new byte wins
         if (stop_sample) begin
            if (!Full || Read) begin
               r_data      <= shift;
               Full        <= 1'b1;
               Frame_error <= !rx_s;
               Overrun     <= 1'b0;
            end else begin
               Overrun     <= 1'b1;
            end
         end else if (Read && Full) begin
            Full        <= 1'b0;
            Overrun     <= 1'b0;
            Frame_error <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Scoreboard bench for uart_rx_controller at 6 clocks per bit.
module tb_uart_rx_controller;
   import uart_pkg::*;

   localparam int CPB = SIM_CLKS_PER_BIT;

   typedef struct packed {
      logic [7:0] data;
      logic       fe;
      logic       ov;
   } exp_t;

   logic       clk;
   logic       Resetn;
   logic       rx_line;
   logic       Read;
   logic [7:0] r_data;
   logic       Full;
   logic       Overrun;
   logic       Frame_error;

   int   total;
   int   bad;
   exp_t expq[$];

   uart_rx_controller #(
      .CLKS_PER_BIT(CPB),
      .HALF_BIT    (3)
   ) dut (
      .clk        (clk),
      .Resetn     (Resetn),
      .UART_RX_I  (rx_line),
      .Read       (Read),
      .r_data     (r_data),
      .Full       (Full),
      .Overrun    (Overrun),
      .Frame_error(Frame_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   // Drives one frame starting now; each bit lasts CPB negedges, line is left at the stop level
   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
      expq.push_back('{data: b, fe: !stop_bit, ov: 1'b0});
      rx_line = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx_line = stop_bit;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic pulseRead();
      Read = 1'b1;
      @(negedge clk);
      Read = 1'b0;
   endtask

   // Monitor: a byte is presented when Full rises or the held byte is replaced while Full
   initial begin
      logic       prev_full;
      logic [7:0] prev_data;
      exp_t       e;
      prev_full = 1'b0;
      prev_data = 8'h00;
      forever begin
         @(negedge clk);
         if (Full === 1'b1 && (prev_full !== 1'b1 || r_data !== prev_data)) begin
            total++;
            if (expq.size() == 0) begin
               bad++;
               $display("[TB] FAIL unexpected_byte actual=%h required=none", r_data);
            end else begin
               e = expq.pop_front();
               if (r_data !== e.data || Frame_error !== e.fe || Overrun !== e.ov) begin
                  bad++;
                  $display("[TB] FAIL byte actual=%h fe=%b ov=%b required=%h fe=%b ov=%b",
                           r_data, Frame_error, Overrun, e.data, e.fe, e.ov);
               end
            end
         end
         prev_full = Full;
         prev_data = r_data;
      end
   end

   initial begin
      total   = 0;
      bad     = 0;
      rx_line = 1'b1;
      Read    = 1'b0;
      Resetn  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_r_data", r_data, 8'h00);
      checkOutput("reset_full", {7'b0, Full}, 8'h00);
      checkOutput("reset_overrun", {7'b0, Overrun}, 8'h00);
      checkOutput("reset_frame_error", {7'b0, Frame_error}, 8'h00);
      Resetn = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] single frame A5");
      fork
         applyStimulus(8'hA5, 1'b1);
         begin
            repeat (59) @(negedge clk);
            checkOutput("full_latency_early", {7'b0, Full}, 8'h00);
            @(negedge clk);
            checkOutput("full_latency_exact", {7'b0, Full}, 8'h01);
         end
      join
      pulseRead();
      checkOutput("a5_read_clears_full", {7'b0, Full}, 8'h00);

      $display("[TB] glitch rejection");
      rx_line = 1'b0;
      repeat (2) @(negedge clk);
      rx_line = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("glitch_full", {7'b0, Full}, 8'h00);
      applyStimulus(8'h3C, 1'b1);
      pulseRead();

      $display("[TB] frame error and break");
      applyStimulus(8'h55, 1'b0);
      repeat (20 * CPB) @(negedge clk);
      rx_line = 1'b1;
      repeat (12) @(negedge clk);
      checkOutput("break_full", {7'b0, Full}, 8'h01);
      checkOutput("break_r_data", r_data, 8'h55);
      checkOutput("break_frame_error", {7'b0, Frame_error}, 8'h01);
      pulseRead();
      checkOutput("break_read_full", {7'b0, Full}, 8'h00);
      checkOutput("break_read_frame_error", {7'b0, Frame_error}, 8'h00);
      applyStimulus(8'h0F, 1'b1);
      pulseRead();

      $display("[TB] overrun");
      applyStimulus(8'h11, 1'b1);
      applyStimulus(8'h22, 1'b1);
      void'(expq.pop_back());
      repeat (2) @(negedge clk);
      checkOutput("overrun_r_data", r_data, 8'h11);
      checkOutput("overrun_flag", {7'b0, Overrun}, 8'h01);
      checkOutput("overrun_full", {7'b0, Full}, 8'h01);
      pulseRead();
      checkOutput("overrun_read_full", {7'b0, Full}, 8'h00);
      checkOutput("overrun_read_flag", {7'b0, Overrun}, 8'h00);

      $display("[TB] read collision");
      applyStimulus(8'h33, 1'b1);
      fork
         applyStimulus(8'h99, 1'b1);
         begin
            repeat (59) @(negedge clk);
            pulseRead();
         end
      join
      checkOutput("collision_full", {7'b0, Full}, 8'h01);
      checkOutput("collision_overrun", {7'b0, Overrun}, 8'h00);
      checkOutput("collision_r_data", r_data, 8'h99);

      $display("[TB] reset mid-frame");
      fork
         begin
            applyStimulus(8'hE5, 1'b1);
            void'(expq.pop_back());
         end
         begin
            repeat (33) @(negedge clk);
            Resetn = 1'b0;
            repeat (2) @(negedge clk);
            checkOutput("midreset_r_data", r_data, 8'h00);
            checkOutput("midreset_full", {7'b0, Full}, 8'h00);
            checkOutput("midreset_overrun", {7'b0, Overrun}, 8'h00);
            checkOutput("midreset_frame_error", {7'b0, Frame_error}, 8'h00);
            repeat (2) @(negedge clk);
            Resetn = 1'b1;
         end
      join
      repeat (4) @(negedge clk);
      checkOutput("after_reset_full", {7'b0, Full}, 8'h00);
      applyStimulus(8'hC3, 1'b1);
      checkOutput("c3_r_data", r_data, 8'hC3);
      pulseRead();
      checkOutput("c3_read_full", {7'b0, Full}, 8'h00);

      repeat (10) @(negedge clk);
      checkOutput("scoreboard_empty", 8'(expq.size()), 8'h00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
